branch_controller: RTL and testbench
====================================

BRANCH_CONTROLLER -- requirements
Module: branch_controller

Interface
REQ-001 Parameter ADDR_W, default 32, width of branch target address.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of cycles FlushD/FlushE stay high after a taken branch; legal range 1..15.
REQ-003 Parameter CNT_W, default 16, width of taken-branch counter.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-006 StallE  input  1  execute stage held; no new instruction accepted.
REQ-007 BranchE  input  1  execute-stage instruction is a branch.
REQ-008 CondE  input  3  branch condition code.
REQ-009 FlagWriteE  input  1  execute-stage instruction writes flags.
REQ-010 ALUFlagsE  input  4  ALU flags {V,C,Z,N}, bit0=N, bit1=Z, bit2=C, bit3=V.
REQ-011 TargetE  input  ADDR_W  computed branch target.
REQ-012 PCSrc  output  1  select branch target at fetch, one-cycle pulse.
REQ-013 BranchTarget  output  ADDR_W  registered target, valid while PCSrc=1.
REQ-014 FlushD  output  1  squash decode stage.
REQ-015 FlushE  output  1  squash execute stage.
REQ-016 Busy  output  1  controller in FLUSH state.
REQ-017 IllegalCond  output  1  one-cycle pulse for undefined condition code.
REQ-018 FlagsQ  output  4  current architectural flag register.
REQ-019 TakenCount  output  CNT_W  count of taken branches.

Function
REQ-020 Condition codes: 3'b111 AL (always), 3'b011 EQ (Z), 3'b100 NE (~Z), 3'b101 GT (~Z & ~(N^V)), 3'b110 LT (N^V); all other codes undefined.
REQ-021 Accept condition: state IDLE and StallE=0; no input is acted on otherwise.
REQ-022 Branch evaluation uses FlagsQ as held before the current edge, never ALUFlagsE.
REQ-023 FlagsQ loads ALUFlagsE on an accepted cycle with FlagWriteE=1; otherwise holds.
REQ-024 Same-cycle BranchE=1 and FlagWriteE=1: branch evaluates old FlagsQ, FlagsQ updates at the same edge.
REQ-025 Taken branch accepted at edge N: PCSrc=1 and BranchTarget=TargetE during cycle N+1 only; FlushD=FlushE=1 for cycles N+1..N+FLUSH_CYCLES; state moves IDLE->FLUSH.
REQ-026 Not-taken defined branch: no output change except FlagsQ per REQ-023; state stays IDLE.
REQ-027 Undefined CondE with BranchE=1: treated not taken, IllegalCond=1 for cycle N+1 only, no flush.
REQ-028 FLUSH state: down-counter loaded with FLUSH_CYCLES-1; decrements each cycle; returns to IDLE when it reaches 0 at an edge.
REQ-029 In FLUSH, BranchE and FlagWriteE are ignored (squashed bubbles); StallE does not pause the counter.
REQ-030 Busy=1 exactly while state is FLUSH.
REQ-031 BranchTarget holds its last value when PCSrc=0.
REQ-032 TakenCount increments by 1 per taken branch and saturates at all-ones.
REQ-033 Back-to-back: a branch in the first IDLE cycle after FLUSH is accepted normally.

Reset
REQ-034 rst=0 at any edge, including mid-FLUSH: state IDLE, counter 0, FlagsQ=0, TakenCount=0, BranchTarget=0, PCSrc=FlushD=FlushE=Busy=IllegalCond=0 from the following cycle.
REQ-035 Inputs during reset cycles have no effect.

Verification
REQ-036 FlagWriteE=1, ALUFlagsE=4'b0010 accepted; next cycle BranchE=1, CondE=3'b011, TargetE=0x100 -> PCSrc=1, BranchTarget=0x100 one cycle; FlushD/FlushE high 2 cycles; TakenCount=1.
REQ-037 FlagsQ=0; BranchE=1, CondE=3'b011 -> no PCSrc, no flush, Busy=0.
REQ-038 Same cycle FlagWriteE=1, ALUFlagsE=4'b0010, BranchE=1, CondE=3'b011, FlagsQ=0 -> not taken; FlagsQ=4'b0010 next cycle.
REQ-039 BranchE=1, CondE=3'b000 -> IllegalCond pulse one cycle, no flush, TakenCount unchanged.
REQ-040 CondE=3'b111 taken, rst=0 on first FLUSH cycle -> all outputs 0 next cycle; BranchE during FLUSH with StallE=1 ignored, flush length still FLUSH_CYCLES.
REQ-041 Preload TakenCount to all-ones via 2^CNT_W-1 taken branches (CNT_W=4 build) -> further taken branch leaves TakenCount=4'hF.

Source files
------------

// File: rtl/branch_controller.sv
// rtl/branch_controller.sv - execute-stage branch resolution, flag register and pipeline flush control
//
// Resolves conditional branches in the execute stage against the architectural
// flag register. A taken branch redirects fetch for one cycle and squashes
// decode and execute for FLUSH_CYCLES cycles.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-low reset
//   StallE        execute stage held, nothing is accepted
//   BranchE       execute-stage instruction is a branch
//   CondE[2:0]    branch condition code
//   FlagWriteE    execute-stage instruction writes the flags
//   ALUFlagsE     ALU flags, bit0=N bit1=Z bit2=C bit3=V
//   TargetE       computed branch target
//   PCSrc         one-cycle pulse selecting BranchTarget at fetch
//   BranchTarget  registered target, valid while PCSrc=1, holds otherwise
//   FlushD        squash decode stage
//   FlushE        squash execute stage
//   Busy          controller in FLUSH state
//   IllegalCond   one-cycle pulse for an undefined condition code
//   FlagsQ        architectural flag register
//   TakenCount    saturating count of taken branches

module branch_controller #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallE,
    input  logic              BranchE,
    input  logic [2:0]        CondE,
    input  logic              FlagWriteE,
    input  logic [3:0]        ALUFlagsE,
    input  logic [ADDR_W-1:0] TargetE,
    output logic              PCSrc,
    output logic [ADDR_W-1:0] BranchTarget,
    output logic              FlushD,
    output logic              FlushE,
    output logic              Busy,
    output logic              IllegalCond,
    output logic [3:0]        FlagsQ,
    output logic [CNT_W-1:0]  TakenCount
);

    // Condition codes
    localparam logic [2:0] COND_EQ = 3'b011;
    localparam logic [2:0] COND_NE = 3'b100;
    localparam logic [2:0] COND_GT = 3'b101;
    localparam logic [2:0] COND_LT = 3'b110;
    localparam logic [2:0] COND_AL = 3'b111;

    // The flush counter counts down to zero and leaves FLUSH on the edge after
    // it reads zero, so loading FLUSH_CYCLES-1 gives exactly FLUSH_CYCLES
    // cycles in FLUSH.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    logic       accept;
    logic       cond_defined;
    logic       cond_true;
    logic       take;
    logic       illegal;

    logic       flag_n;
    logic       flag_z;
    logic       flag_v;

    // Evaluation always uses the registered flags, so a flag-writing branch
    // sees the flags from before its own update.
    assign flag_n = FlagsQ[0];
    assign flag_z = FlagsQ[1];
    assign flag_v = FlagsQ[3];

    assign accept = (state_q == ST_IDLE) && !StallE;

    always_comb begin
        cond_defined = 1'b1;
        cond_true    = 1'b0;
        case (CondE)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = flag_z;
            COND_NE: cond_true = !flag_z;
            COND_GT: cond_true = !flag_z && !(flag_n ^ flag_v);
            COND_LT: cond_true = flag_n ^ flag_v;
            default: cond_defined = 1'b0;
        endcase
    end

    assign take    = accept && BranchE && cond_defined && cond_true;
    assign illegal = accept && BranchE && !cond_defined;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                // Runs regardless of StallE; the squashed bubbles carry nothing.
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            PCSrc        <= 1'b0;
            IllegalCond  <= 1'b0;
            BranchTarget <= '0;
            FlagsQ       <= 4'd0;
            TakenCount   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            PCSrc       <= take;
            IllegalCond <= illegal;
            if (take) begin
                BranchTarget <= TargetE;
            end
            if (accept && FlagWriteE) begin
                FlagsQ <= ALUFlagsE;
            end
            if (take && (TakenCount != {CNT_W{1'b1}})) begin
                TakenCount <= TakenCount + 1'b1;
            end
        end
    end

    assign Busy   = (state_q == ST_FLUSH);
    assign FlushD = Busy;
    assign FlushE = Busy;

endmodule

// File: tb/tb_branch_controller.sv
// tb/tb_branch_controller.sv - directed self-checking bench for branch_controller

module tb_branch_controller;

    logic        clk;
    logic        rst;
    logic        StallE;
    logic        BranchE;
    logic [2:0]  CondE;
    logic        FlagWriteE;
    logic [3:0]  ALUFlagsE;
    logic [31:0] TargetE;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        FlushD;
    logic        FlushE;
    logic        Busy;
    logic        IllegalCond;
    logic [3:0]  FlagsQ;
    logic [3:0]  TakenCount;

    int checks;
    int errors;

    branch_controller #(
        .ADDR_W      (32),
        .FLUSH_CYCLES(2),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .StallE      (StallE),
        .BranchE     (BranchE),
        .CondE       (CondE),
        .FlagWriteE  (FlagWriteE),
        .ALUFlagsE   (ALUFlagsE),
        .TargetE     (TargetE),
        .PCSrc       (PCSrc),
        .BranchTarget(BranchTarget),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .Busy        (Busy),
        .IllegalCond (IllegalCond),
        .FlagsQ      (FlagsQ),
        .TakenCount  (TakenCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        StallE     = 1'b0;
        BranchE    = 1'b0;
        CondE      = 3'b000;
        FlagWriteE = 1'b0;
        ALUFlagsE  = 4'd0;
        TargetE    = 32'd0;
    endtask

    task automatic branch(input logic [2:0] cond, input logic [31:0] tgt);
        BranchE = 1'b1;
        CondE   = cond;
        TargetE = tgt;
    endtask

    task automatic write_flags(input logic [3:0] f);
        FlagWriteE = 1'b1;
        ALUFlagsE  = f;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with noisy inputs: nothing may leak through.
        idle_inputs();
        rst = 1'b0;
        branch(3'b111, 32'hDEAD_BEEF);
        write_flags(4'hF);
        step();
        step();
        idle_inputs();
        rst = 1'b1;
        check("rst_pcsrc", PCSrc, 0);
        check("rst_busy", Busy, 0);
        check("rst_flushd", FlushD, 0);
        check("rst_flags", FlagsQ, 0);
        check("rst_count", TakenCount, 0);
        check("rst_target", BranchTarget, 0);
        check("rst_illegal", IllegalCond, 0);

        // EQ taken after Z is set.
        write_flags(4'b0010);
        step();
        idle_inputs();
        check("eq_flags", FlagsQ, 4'b0010);
        check("eq_pre_pcsrc", PCSrc, 0);
        branch(3'b011, 32'h100);
        step();
        idle_inputs();
        check("eq_pcsrc", PCSrc, 1);
        check("eq_target", BranchTarget, 32'h100);
        check("eq_flushd1", FlushD, 1);
        check("eq_flushe1", FlushE, 1);
        check("eq_busy1", Busy, 1);
        check("eq_count", TakenCount, 1);
        step();
        check("eq_pcsrc2", PCSrc, 0);
        check("eq_flushd2", FlushD, 1);
        check("eq_flushe2", FlushE, 1);
        check("eq_target_hold", BranchTarget, 32'h100);
        step();
        check("eq_flushd3", FlushD, 0);
        check("eq_busy3", Busy, 0);

        // EQ not taken with Z clear.
        write_flags(4'b0000);
        step();
        idle_inputs();
        branch(3'b011, 32'h111);
        step();
        idle_inputs();
        check("eqnt_pcsrc", PCSrc, 0);
        check("eqnt_flush", FlushD, 0);
        check("eqnt_busy", Busy, 0);
        check("eqnt_target", BranchTarget, 32'h100);

        // Same-cycle flag write and branch: old flags decide.
        write_flags(4'b0010);
        branch(3'b011, 32'h122);
        step();
        idle_inputs();
        check("same_pcsrc", PCSrc, 0);
        check("same_flags", FlagsQ, 4'b0010);
        check("same_busy", Busy, 0);

        // N=1, V=0: GT false, LT true.
        write_flags(4'b0001);
        step();
        idle_inputs();
        branch(3'b101, 32'h1F0);
        step();
        idle_inputs();
        check("gt_pcsrc", PCSrc, 0);
        branch(3'b100, 32'h0);
        write_flags(4'b0001);
        idle_inputs();
        branch(3'b110, 32'h200);
        step();
        check("lt_pcsrc", PCSrc, 1);
        check("lt_target", BranchTarget, 32'h200);
        check("lt_count", TakenCount, 2);
        // Inputs during FLUSH, stalled or not, are ignored.
        idle_inputs();
        StallE = 1'b1;
        branch(3'b111, 32'h2F0);
        write_flags(4'hF);
        step();
        check("fl_busy", Busy, 1);
        check("fl_pcsrc", PCSrc, 0);
        check("fl_flags", FlagsQ, 4'b0001);
        StallE = 1'b0;
        step();
        check("fl_busy_end", Busy, 0);
        check("fl_pcsrc_end", PCSrc, 0);
        check("fl_flags_end", FlagsQ, 4'b0001);
        check("fl_count", TakenCount, 2);

        // Back-to-back: branch in the first IDLE cycle after FLUSH.
        idle_inputs();
        branch(3'b111, 32'h300);
        step();
        idle_inputs();
        check("b2b_pcsrc", PCSrc, 1);
        check("b2b_target", BranchTarget, 32'h300);
        check("b2b_count", TakenCount, 3);
        step();
        step();
        check("b2b_idle", Busy, 0);

        // NE taken with Z clear.
        branch(3'b100, 32'h350);
        step();
        idle_inputs();
        check("ne_pcsrc", PCSrc, 1);
        check("ne_target", BranchTarget, 32'h350);
        step();
        step();

        // Undefined condition.
        branch(3'b000, 32'h380);
        step();
        idle_inputs();
        check("ill_pulse", IllegalCond, 1);
        check("ill_pcsrc", PCSrc, 0);
        check("ill_busy", Busy, 0);
        check("ill_count", TakenCount, 4);
        step();
        check("ill_clear", IllegalCond, 0);

        // Stall in IDLE blocks both branch and flag write.
        StallE = 1'b1;
        branch(3'b111, 32'h390);
        write_flags(4'b0100);
        step();
        idle_inputs();
        check("stall_pcsrc", PCSrc, 0);
        check("stall_flags", FlagsQ, 4'b0001);
        check("stall_busy", Busy, 0);

        // Reset on the first FLUSH cycle.
        branch(3'b111, 32'h400);
        step();
        idle_inputs();
        check("mid_pcsrc", PCSrc, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid_pcsrc0", PCSrc, 0);
        check("mid_flushd", FlushD, 0);
        check("mid_flushe", FlushE, 0);
        check("mid_busy", Busy, 0);
        check("mid_illegal", IllegalCond, 0);
        check("mid_flags", FlagsQ, 0);
        check("mid_count", TakenCount, 0);
        check("mid_target", BranchTarget, 0);

        // Saturation: 15 taken branches, then one more.
        for (int i = 0; i < 15; i++) begin
            branch(3'b111, 32'h500 + i);
            step();
            idle_inputs();
            step();
            step();
        end
        check("sat_preload", TakenCount, 4'hF);
        branch(3'b111, 32'h600);
        step();
        idle_inputs();
        check("sat_pcsrc", PCSrc, 1);
        check("sat_count", TakenCount, 4'hF);
        check("sat_target", BranchTarget, 32'h600);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
